alu_ctrl_fsm: RTL and testbench

- Multi-cycle control sequencer that drives the 8-bit datapath ALU.
- Fetches 9-bit instructions from instruction memory, decodes them, and issues the 3-bit ALU op plus register-file and data-memory controls.
- Consumes the ALU branch flag and sequences the program counter.
- Sits between instruction memory, register file, data memory and the ALU as the initiator of every ALU operation.

---
 rtl/alu_ctrl_fsm_pkg.sv | 49 ++++
 rtl/alu_ctrl_fsm_branch_lut.sv | 27 ++
 rtl/alu_ctrl_fsm.sv | 157 +++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared definitions for the ALU control sequencer: op codes, FSM states,
// instruction field layout and branch-table helpers.
package alu_ctrl_fsm_pkg;

    localparam int unsigned INSTR_W = 9;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RA_LSB  = 3;
    localparam int unsigned RB_LSB  = 0;

    // Same encoding the datapath ALU decodes.
    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_XOR  = 3'd1,
        OP_AND  = 3'd2,
        OP_RSL  = 3'd3,
        OP_MOV  = 3'd4,
        OP_LD   = 3'd5,
        OP_ST   = 3'd6,
        OP_BLQZ = 3'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALTED = 3'd6
    } state_e;

    function automatic alu_op_e instr_op(input logic [INSTR_W-1:0] instr);
        return alu_op_e'(instr[OP_LSB +: FIELD_W]);
    endfunction

    function automatic logic [FIELD_W-1:0] instr_ra(input logic [INSTR_W-1:0] instr);
        return instr[RA_LSB +: FIELD_W];
    endfunction

    function automatic logic [FIELD_W-1:0] instr_rb(input logic [INSTR_W-1:0] instr);
        return instr[RB_LSB +: FIELD_W];
    endfunction

    function automatic int unsigned lut_default_entry(input int unsigned idx);
        return idx * 4;
    endfunction

endpackage

// File: rtl/alu_ctrl_fsm_branch_lut.sv
// Combinational branch-target ROM: 3-bit index from the instruction's rb
// field selects a PC_W-wide jump target.
module alu_branch_lut
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned PC_W      = 10,
    parameter int unsigned LUT_DEPTH = 8
) (
    input  logic [2:0]      idx_i,
    output logic [PC_W-1:0] target_o
);

    logic [PC_W-1:0] rom [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_rom
        assign rom[g] = PC_W'(lut_default_entry(g));
    end

    // Indices beyond a shallower table fall back to address 0.
    always_comb begin
        target_o = '0;
        if (32'(idx_i) < LUT_DEPTH) begin
            target_o = rom[idx_i];
        end
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control sequencer: fetches 9-bit instructions, decodes them and
// issues ALU, register-file and data-memory controls, then advances the PC.
module alu_ctrl_fsm
    import alu_ctrl_fsm_pkg::*;
#(
    parameter int unsigned PC_W       = 10,
    parameter logic [8:0]  HALT_INSTR = 9'h1FF,
    parameter int unsigned LUT_DEPTH  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            done,
    output logic [PC_W-1:0] pc,
    output logic            imem_req,
    input  logic            imem_vld,
    input  logic [8:0]      imem_data,
    output logic [2:0]      rf_ra,
    output logic [2:0]      rf_rb,
    output logic [2:0]      rf_wa,
    output logic            rf_we,
    output logic            wb_sel,
    output logic [2:0]      alu_op,
    input  logic            alu_jump,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack
);

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [8:0]      ir_q, ir_d;

    alu_op_e         op;
    logic [2:0]      ra;
    logic [2:0]      rb;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] br_target;

    assign op     = instr_op(ir_q);
    assign ra     = instr_ra(ir_q);
    assign rb     = instr_rb(ir_q);
    assign pc_inc = pc_q + PC_W'(1);

    alu_branch_lut #(
        .PC_W      (PC_W),
        .LUT_DEPTH (LUT_DEPTH)
    ) u_branch_lut (
        .idx_i    (rb),
        .target_o (br_target)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d = ST_FETCH;
                    pc_d    = '0;
                end
            end
            ST_FETCH: begin
                if (imem_vld) begin
                    ir_d    = imem_data;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = (ir_q == HALT_INSTR) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                case (op)
                    OP_BLQZ: begin
                        pc_d    = alu_jump ? br_target : pc_inc;
                        state_d = ST_FETCH;
                    end
                    OP_LD, OP_ST: state_d = ST_MEM;
                    default:      state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_LD) begin
                        state_d = ST_WB;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                pc_d    = pc_inc;
                state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode purely from state so an async reset clears them at once.
    always_comb begin
        done     = 1'b0;
        imem_req = 1'b0;
        rf_ra    = '0;
        rf_rb    = '0;
        rf_wa    = '0;
        rf_we    = 1'b0;
        wb_sel   = 1'b0;
        alu_op   = '0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        case (state_q)
            ST_FETCH: imem_req = 1'b1;
            ST_DECODE: begin
                rf_ra = ra;
                rf_rb = rb;
            end
            ST_EXEC: begin
                rf_ra  = ra;
                rf_rb  = rb;
                alu_op = op;
            end
            ST_MEM: begin
                rf_ra    = ra;
                rf_rb    = rb;
                alu_op   = op;
                dmem_req = 1'b1;
                dmem_we  = (op == OP_ST);
            end
            ST_WB: begin
                rf_ra  = ra;
                rf_rb  = rb;
                rf_wa  = ra;
                rf_we  = 1'b1;
                wb_sel = (op == OP_LD);
            end
            ST_HALTED: done = 1'b1;
            default: ;
        endcase
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Randomized bench for alu_ctrl_fsm: memory responders with random wait
// states and an instruction-level reference model scoring every instruction.
module tb_alu_ctrl_fsm;

    localparam int unsigned PC_W = 10;
    localparam logic [8:0]  HALT = 9'h1FF;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic            done;
    logic [PC_W-1:0] pc;
    logic            imem_req;
    logic            imem_vld = 1'b0;
    logic [8:0]      imem_data = '0;
    logic [2:0]      rf_ra, rf_rb, rf_wa;
    logic            rf_we, wb_sel;
    logic [2:0]      alu_op;
    logic            alu_jump = 1'b0;
    logic            dmem_req, dmem_we;
    logic            dmem_ack = 1'b0;

    always #5 clk = ~clk;

    alu_ctrl_fsm #(
        .PC_W       (PC_W),
        .HALT_INSTR (HALT),
        .LUT_DEPTH  (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .done      (done),
        .pc        (pc),
        .imem_req  (imem_req),
        .imem_vld  (imem_vld),
        .imem_data (imem_data),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_wa     (rf_wa),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .alu_op    (alu_op),
        .alu_jump  (alu_jump),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack)
    );

    logic [8:0] imem [1024];
    int force_iwait = -1;
    int force_dwait = -1;
    int jump_mode = 0;
    int ifetch_len_exp = 1;
    int dlen_exp = 1;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Instruction memory: valid after 0..2 stall cycles per fetch.
    initial begin
        int  icnt;
        bit  busy;
        icnt = 0;
        busy = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n || !imem_req) begin
                imem_vld  = 1'b0;
                busy      = 0;
                imem_data = 9'($urandom);
            end else begin
                if (!busy) begin
                    busy = 1;
                    icnt = (force_iwait >= 0) ? force_iwait : int'($urandom_range(0, 2));
                    ifetch_len_exp = icnt + 1;
                end
                if (icnt == 0) begin
                    imem_vld  = 1'b1;
                    imem_data = imem[pc];
                    busy      = 0;
                end else begin
                    imem_vld  = 1'b0;
                    imem_data = 9'($urandom);
                    icnt--;
                end
            end
        end
    end

    // Data memory: ack after 0..3 extra cycles per request.
    initial begin
        int dcnt;
        bit busy;
        dcnt = 0;
        busy = 0;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n || !dmem_req) begin
                dmem_ack = 1'b0;
                busy     = 0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    dcnt = (force_dwait >= 0) ? force_dwait : int'($urandom_range(0, 3));
                    dlen_exp = dcnt + 1;
                end
                if (dcnt == 0) begin
                    dmem_ack = 1'b1;
                    busy     = 0;
                end else begin
                    dmem_ack = 1'b0;
                    dcnt--;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            alu_jump = (jump_mode == 1) ? 1'b1 : (jump_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
    end

    // Reference model state: one window per fetched instruction.
    bit         win_open = 0;
    bit         stopped = 1;
    bit         halted = 0;
    bit         jump_seen = 0;
    bit         prev_valid = 0;
    bit         seen_wbsel = 0;
    int         w_cyc, n_alu, n_alubad, n_dm, n_webad, n_we, n_rfbad, n_done;
    int         ireq_cnt = 0;
    int         wrap_cnt = 0;
    logic [8:0] w_instr = '0;
    logic [9:0] w_pc = '0, exp_pc = '0, hold_pc = '0, prev_pc = '0;
    logic [2:0] seen_wa = '0;

    task automatic close_window();
        int op, lat, dm_exp;
        bit is_mem;
        op = int'(w_instr[8:6]);
        if (w_instr == HALT) begin
            check_eq("halt_done", n_done, 1);
        end else begin
            is_mem = (op == 5) || (op == 6);
            dm_exp = is_mem ? dlen_exp : 0;
            lat    = (op == 7) ? 3 : (op == 5) ? 5 : 4;
            if (is_mem) lat += dlen_exp - 1;
            check_eq("latency", w_cyc, lat);
            check_eq("alu_cycles", n_alu, (op == 0) ? 0 : 1 + dm_exp);
            check_eq("alu_value", n_alubad, 0);
            check_eq("dmem_cycles", n_dm, dm_exp);
            if (is_mem) check_eq("dmem_we", n_webad, 0);
            check_eq("rf_we_count", n_we, (op <= 5) ? 1 : 0);
            if (op <= 5 && n_we != 0) begin
                check_eq("rf_wa", seen_wa, w_instr[5:3]);
                check_eq("wb_sel", seen_wbsel, (op == 5) ? 1 : 0);
            end
            check_eq("rf_read_addr", n_rfbad, 0);
            check_eq("done_busy", n_done, 0);
            if (op == 7 && jump_seen) exp_pc = 10'(int'(w_instr[2:0]) * 4);
            else                      exp_pc = 10'((int'(w_pc) + 1) % 1024);
        end
        prev_pc    = w_pc;
        prev_valid = 1;
        win_open   = 0;
    endtask

    always @(negedge clk) begin
        if (!reset_n) begin
            win_open = 0; stopped = 1; halted = 0; hold_pc = '0;
            exp_pc = '0; ireq_cnt = 0; prev_valid = 0;
        end else begin
            if (stopped) begin
                check_eq("done_level", done, halted);
                check_eq("req_stopped", imem_req, 0);
                check_eq("pc_hold", pc, hold_pc);
            end else begin
                if (imem_req && win_open) close_window();
                if (win_open) begin
                    w_cyc++;
                    if (alu_op != 0) begin
                        n_alu++;
                        if (alu_op != w_instr[8:6]) n_alubad++;
                        if (alu_op == 3'd7) jump_seen = alu_jump;
                    end
                    if (dmem_req) begin
                        n_dm++;
                        if (dmem_we != (w_instr[8:6] == 3'd6)) n_webad++;
                    end
                    if ((dmem_req || rf_we) && (rf_ra != w_instr[5:3] || rf_rb != w_instr[2:0])) n_rfbad++;
                    if (rf_we) begin
                        n_we++;
                        seen_wa    = rf_wa;
                        seen_wbsel = wb_sel;
                    end
                    if (done) n_done++;
                    if (done && w_instr == HALT) begin
                        check_eq("halt_latency", w_cyc, 3);
                        check_eq("halt_pc", pc, w_pc);
                        win_open = 0; stopped = 1; halted = 1; hold_pc = w_pc;
                    end
                end
                if (imem_req && !stopped) begin
                    ireq_cnt++;
                    if (imem_vld) begin
                        check_eq("fetch_pc", pc, exp_pc);
                        check_eq("fetch_req_cycles", ireq_cnt, ifetch_len_exp);
                        if (prev_valid && prev_pc == 10'd1023 && pc == 10'd0) wrap_cnt++;
                        ireq_cnt = 0;
                        win_open = 1; w_instr = imem_data; w_pc = pc; w_cyc = 1;
                        n_alu = 0; n_alubad = 0; n_dm = 0; n_webad = 0;
                        n_we = 0; n_rfbad = 0; n_done = 0; jump_seen = 0;
                    end
                end
            end
            if (stopped && start) begin
                stopped = 0; halted = 0; exp_pc = '0; ireq_cnt = 0; prev_valid = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(posedge clk);
        #1;
        check_eq("done_reached", done, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #3 reset_n = 1'b0;
        @(posedge clk); #3 reset_n = 1'b1;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        for (int i = 0; i < 1024; i++) imem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_imem_req", imem_req, 0);
        check_eq("rst_pc", pc, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_alu_op", alu_op, 0);
        check_eq("rst_rf_we", rf_we, 0);
        check_eq("rst_dmem_req", dmem_req, 0);
        @(posedge clk); #3 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_eq("idle_no_fetch", imem_req, 0);

        // ADD, LD with 3-cycle ack delay, BLQZ taken then not taken.
        imem[0] = 9'h00A; imem[1] = 9'h150; imem[2] = 9'h1C3;
        imem[3] = HALT;   imem[12] = HALT;
        force_dwait = 3; jump_mode = 1;
        pulse_start();
        wait_done(200);
        check_eq("blqz_taken_pc", pc, 12);
        jump_mode = 2;
        pulse_start();
        wait_done(200);
        check_eq("blqz_fall_pc", pc, 3);
        force_dwait = -1; jump_mode = 0;

        // Halt at pc 5, then restart.
        for (int i = 0; i < 5; i++) imem[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
        imem[5] = HALT;
        pulse_start();
        wait_done(300);
        check_eq("halt_pc5", pc, 5);
        repeat ($urandom_range(1, 5)) @(posedge clk);
        pulse_start();
        check_eq("restart_done", done, 0);
        check_eq("restart_pc", pc, 0);
        check_eq("restart_fetch", imem_req, 1);
        wait_done(300);
        check_eq("halt_pc5_again", pc, 5);

        // Asynchronous reset while a fetch is stalled.
        force_iwait = 6;
        pulse_start();
        @(posedge clk); #3;
        check_eq("midfetch_req", imem_req, 1);
        reset_n = 1'b0;
        #1;
        check_eq("midfetch_rst_req", imem_req, 0);
        check_eq("midfetch_rst_pc", pc, 0);
        check_eq("midfetch_rst_alu_op", alu_op, 0);
        @(posedge clk); #3 reset_n = 1'b1;
        force_iwait = -1;
        repeat (4) @(posedge clk);
        #1 check_eq("post_rst_idle", imem_req, 0);

        // Straight-line program through pc 1023 (XOR) and back to 0.
        for (int i = 0; i < 1024; i++) imem[i] = {3'($urandom_range(0, 6)), 6'($urandom)};
        imem[1023] = {3'd1, 6'($urandom)};
        base = wrap_cnt;
        pulse_start();
        for (int i = 0; i < 15000 && wrap_cnt == base; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        check_eq("pc_wrap", (wrap_cnt > base) ? 1 : 0, 1);
        do_reset();

        // Fully random programs with sprinkled halts and stray start pulses.
        for (int i = 0; i < 1024; i++)
            imem[i] = ($urandom_range(0, 29) == 0) ? HALT : 9'($urandom);
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2 start = ($urandom_range(0, 39) == 0);
        end
        start = 1'b0;
        do_reset();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
